// File: rtl/useq_ctrl.sv
// useq_ctrl -- next-address controller for a cascade of 4-bit microprogram
// sequencer slices. Every slice in the cascade receives the same control
// outputs.
//
// The controller decodes a 3-bit next-address opcode plus a condition into
// the slice control pins. It also keeps state the slices do not have:
//   - a loop counter,
//   - a stack-depth tracker,
//   - sticky overflow/underflow flags,
//   - a hold (stall) mode.
//
// Ports
//   clock     in   system clock, state updates on rising edge
//   reset     in   synchronous active-high reset
//   opcode    in   next-address instruction
//                    0 JZ, 1 CJS, 2 JMAP, 3 CJP,
//                    4 PUSH, 5 RFCT, 6 CRTN, 7 CONT
//   cc        in   condition, active-high
//   ccen_n    in   0 = test cc, 1 = condition forced pass
//   ar_ld     in   load slice address register from slice D this cycle
//   hold      in   stall: slice PC reloads itself, internal state frozen
//   clr_err   in   clear ovf/unf (a same-cycle new error wins)
//   cnt_din   in   loop counter load value
//   s1, s0    out  slice source select: 00 PC, 01 AR, 10 stack, 11 D
//   zero_n    out  0 = force slice output to zero
//   cin       out  slice PC increment carry-in
//   re_n      out  0 = load slice AR
//   fe_n      out  0 = stack operation enabled
//   pup       out  with fe_n=0: 1 push, 0 pop
//   cnt_zero  out  loop counter == 0
//   depth     out  tracked stack occupancy
//   ovf       out  sticky: push issued while the stack was full
//   unf       out  sticky: pop issued while the stack was empty
//
// Control outputs are combinational from the inputs and registered state,
// so the slices see them in the same cycle the opcode is presented.

module useq_ctrl #(
   parameter int CNT_W       = 8,
   parameter int STACK_DEPTH = 4,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [2:0]         opcode,
   input  logic               cc,
   input  logic               ccen_n,
   input  logic               ar_ld,
   input  logic               hold,
   input  logic               clr_err,
   input  logic [CNT_W-1:0]   cnt_din,
   output logic               s1,
   output logic               s0,
   output logic               zero_n,
   output logic               cin,
   output logic               re_n,
   output logic               fe_n,
   output logic               pup,
   output logic               cnt_zero,
   output logic [DEPTH_W-1:0] depth,
   output logic               ovf,
   output logic               unf
);

   localparam logic [2:0] OP_JZ   = 3'd0;
   localparam logic [2:0] OP_CJS  = 3'd1;
   localparam logic [2:0] OP_JMAP = 3'd2;
   localparam logic [2:0] OP_CJP  = 3'd3;
   localparam logic [2:0] OP_PUSH = 3'd4;
   localparam logic [2:0] OP_RFCT = 3'd5;
   localparam logic [2:0] OP_CRTN = 3'd6;
   localparam logic [2:0] OP_CONT = 3'd7;

   localparam logic [1:0] SRC_PC  = 2'b00;
   localparam logic [1:0] SRC_STK = 2'b10;
   localparam logic [1:0] SRC_D   = 2'b11;

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

   // Registered state
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               ovf_q,   ovf_d;
   logic               unf_q,   unf_d;

   // Decoded controls
   logic               pass;
   logic [1:0]         src;
   logic               zero_n_c, cin_c, re_n_c, fe_n_c, pup_c;
   logic               ld_cnt, dec_cnt, clr_depth;
   logic               cnt_is_zero;
   logic               push, pop;
   logic               depth_full, depth_empty;

   assign pass        = ccen_n | cc;
   assign cnt_is_zero = (cnt_q == '0);

   // Instruction decode. reset and hold take precedence over the opcode
   // so the slices always get a defined control word.
   always_comb begin
      src       = SRC_PC;
      zero_n_c  = 1'b1;
      cin_c     = 1'b1;
      re_n_c    = ~ar_ld;
      fe_n_c    = 1'b1;
      pup_c     = 1'b0;
      ld_cnt    = 1'b0;
      dec_cnt   = 1'b0;
      clr_depth = 1'b0;

      if (reset) begin
         // Zeroed output with no carry: slice PC becomes 0.
         zero_n_c = 1'b0;
         cin_c    = 1'b0;
         re_n_c   = 1'b1;
      end else if (hold) begin
         // Select PC with no carry so the slice PC reloads its own value.
         cin_c  = 1'b0;
         re_n_c = 1'b1;
      end else begin
         case (opcode)
            OP_JZ: begin
               zero_n_c  = 1'b0;
               clr_depth = 1'b1;
            end
            OP_CJS: begin
               if (pass) begin
                  src    = SRC_D;
                  fe_n_c = 1'b0;
                  pup_c  = 1'b1;
               end
            end
            OP_JMAP: begin
               src = SRC_D;
            end
            OP_CJP: begin
               if (pass) src = SRC_D;
            end
            OP_PUSH: begin
               fe_n_c = 1'b0;
               pup_c  = 1'b1;
               ld_cnt = pass;
            end
            OP_RFCT: begin
               // Loop back to the stack top while the count is non-zero;
               // on zero, drop the loop address and fall through.
               if (!cnt_is_zero) begin
                  src     = SRC_STK;
                  dec_cnt = 1'b1;
               end else begin
                  fe_n_c = 1'b0;
               end
            end
            OP_CRTN: begin
               if (pass) begin
                  src    = SRC_STK;
                  fe_n_c = 1'b0;
               end
            end
            OP_CONT: begin
               src = SRC_PC;
            end
            default: begin
               src = SRC_PC;
            end
         endcase
      end
   end

   assign push        = ~fe_n_c &  pup_c;
   assign pop         = ~fe_n_c & ~pup_c;
   assign depth_full  = (depth_q == DEPTH_MAX);
   assign depth_empty = (depth_q == '0);

   // Next-state logic. Under reset or hold no stack op is decoded and
   // ld/dec/clr are all low, so state is naturally frozen apart from
   // clr_err, which is honoured even while holding.
   always_comb begin
      cnt_d = cnt_q;
      if (ld_cnt)       cnt_d = cnt_din;
      else if (dec_cnt) cnt_d = cnt_q - 1'b1;

      depth_d = depth_q;
      if (clr_depth)                depth_d = '0;
      else if (push && !depth_full) depth_d = depth_q + 1'b1;
      else if (pop && !depth_empty) depth_d = depth_q - 1'b1;

      // The slices still see the op and wrap; only the flag records it.
      ovf_d = (ovf_q & ~clr_err) | (push & depth_full);
      unf_d = (unf_q & ~clr_err) | (pop & depth_empty);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign s1       = src[1];
   assign s0       = src[0];
   assign zero_n   = zero_n_c;
   assign cin      = cin_c;
   assign re_n     = re_n_c;
   assign fe_n     = fe_n_c;
   assign pup      = pup_c;
   assign cnt_zero = cnt_is_zero;
   assign depth    = depth_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;

endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
Next-address controller that drives a cascade of 4-bit microprogram sequencer slices, one slice per nibble of the microaddress. It decodes a 3-bit next-address opcode and a condition input into the slice control pins. It also adds what the slices lack:
- a loop counter;
- a stack-depth tracker;
- sticky overflow/underflow flags;
- a hold (stall) mode.

It sits between the microinstruction register and the slice control inputs. Every slice in the cascade receives the same control outputs.

Parameters:
CNT_W, 8, loop counter width.
STACK_DEPTH, 4, slice stack depth (entries); depth tracker saturates here.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  3  next-address instruction (encoding below)
cc  in  1  condition, active-high
ccen_n  in  1  0 = test cc; 1 = condition forced pass
ar_ld  in  1  1 = load slice address register from slice D this cycle
hold  in  1  1 = stall: freeze microaddress and all state
clr_err  in  1  1 = clear ovf/unf
cnt_din  in  CNT_W  loop counter load value
s1, s0  out  1 each  slice source select: 00 PC, 01 AR, 10 stack, 11 D
zero_n  out  1  0 = force slice output to zero
cin  out  1  slice PC increment carry-in
re_n  out  1  0 = load slice AR
fe_n  out  1  0 = stack operation enabled
pup  out  1  with fe_n=0: 1 push, 0 pop
cnt_zero  out  1  loop counter == 0
depth  out  clog2(STACK_DEPTH+1)  tracked stack occupancy
ovf  out  1  sticky: push issued at depth==STACK_DEPTH
unf  out  1  sticky: pop issued at depth==0

Behaviour:
- Control outputs are combinational from the inputs plus registered state, so there is zero-cycle latency to the slices. Internal state updates on the rising clock edge.
- pass = ccen_n | cc.
- Defaults for every opcode unless overridden below: s=00, zero_n=1, cin=1, fe_n=1, pup=0, re_n=~ar_ld.
- Opcode table:
  - 0 JZ: zero_n=0 (address 0, PC becomes 1); depth <= 0; counter unchanged.
  - 1 CJS: if pass, s=11, fe_n=0, pup=1 (push return address = current PC); else continue.
  - 2 JMAP: s=11 unconditionally.
  - 3 CJP: if pass, s=11; else continue.
  - 4 PUSH: fe_n=0, pup=1, continue; if pass, counter <= cnt_din.
  - 5 RFCT: if counter!=0, s=10 with no stack op, and counter <= counter-1. If counter==0, pop (fe_n=0, pup=0) and continue.
  - 6 CRTN: if pass, s=10 and pop; else continue.
  - 7 CONT: continue.
- depth tracking:
  - push: depth+1, saturating at STACK_DEPTH; if depth was already STACK_DEPTH, set ovf. The push is still issued to the slices (they wrap).
  - pop: depth-1, saturating at 0; if depth was 0, set unf. The pop is still issued.
- clr_err clears ovf and unf. If a new error occurs in the same cycle, the set wins.
- hold=1 overrides the opcode:
  - outputs: s=00, zero_n=1, cin=0, fe_n=1, re_n=1 (slice PC reloads itself);
  - counter, depth, ovf and unf do not change;
  - clr_err is still honoured.
- reset=1 overrides everything:
  - outputs: s=00, zero_n=0, cin=0, fe_n=1, re_n=1, pup=0 (slice PC becomes 0);
  - next state: counter=0, depth=0, ovf=0, unf=0, so cnt_zero=1 after reset;
  - takes effect at the next edge, even mid-loop or mid-hold.
- Counter arithmetic is modulo 2^CNT_W. RFCT never decrements below 0, because the zero case takes the pop branch instead.
- No X on outputs for any opcode/input combination.

Test Plan:
1. Reset, then CONT x3 → s=00, cin=1 each cycle; slice address 0,1,2,3; depth=0, cnt_zero=1, ovf=unf=0.
2. PUSH with pass, cnt_din=3, then RFCT x4 → RFCT cycles 1-3 give s=10, fe_n=1, counter 2,1,0; cycle 4 gives fe_n=0, pup=0, s=00; depth 1→0.
3. CJS with ccen_n=0, cc=1, D=0x5 → s=11, fe_n=0, pup=1, depth=1. Then CRTN with cc=1 → s=10, pop, depth=0. Repeat with cc=0 → s=00, no stack op.
4. Five consecutive PUSH from depth 0 → depth 1,2,3,4,4; ovf=1 after the 5th. Then clr_err → ovf=0. CRTN pass x5 → depth to 0, unf=1 after the 5th.
5. hold=1 for 3 cycles during an RFCT loop with counter=2 → cin=0, fe_n=1 throughout; counter stays 2, depth unchanged. After release the loop resumes at 2.
6. reset asserted mid-loop (counter=5, depth=2, ovf=1) → same cycle zero_n=0, cin=0; next cycle counter=0, depth=0, ovf=0.
